// File: rtl/ahci_fis_transmit_pkg.sv
// rtl/ahci_fis_transmit_pkg.sv - shared codes, states and helpers for the FIS transmitter
package ahci_fis_transmit_pkg;

    // todev_type codes seen by the transport-layer FIFO
    localparam logic [1:0] TODEV_DATA = 2'd0;
    localparam logic [1:0] TODEV_HEAD = 2'd1;
    localparam logic [1:0] TODEV_LAST = 2'd2;

    // FIS type byte of a data FIS header
    localparam logic [7:0] FIS_TYPE_DATA = 8'h46;

    // Entries in the read-latency skid buffer
    localparam int SKID_DEPTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFIS,
        ST_DHEAD,
        ST_DDATA,
        ST_WSTAT
    } xmit_state_t;

    function automatic logic [31:0] data_fis_header(input logic [3:0] pm_port);
        return {16'h0, 4'h0, pm_port, FIS_TYPE_DATA};
    endfunction

endpackage

// File: rtl/ahci_fis_xmit_skid.sv
// rtl/ahci_fis_xmit_skid.sv - 4-entry FIFO holding command FIS DWORDs plus type tag
//
// Ports:
//   i_clk, i_rst    clock, asynchronous active-high reset
//   i_flush         drop all entries
//   i_push, i_data  write one {type, DWORD} entry (caller never pushes when full)
//   i_pop           consume head entry (ignored when empty)
//   o_data          head entry
//   o_count         number of entries held (0..4)
//   o_empty, o_full status
module ahci_fis_xmit_skid
    import ahci_fis_transmit_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [33:0] i_data,
    input  logic        i_pop,
    output logic [33:0] o_data,
    output logic [2:0]  o_count,
    output logic        o_empty,
    output logic        o_full
);

    logic [33:0] r_mem [SKID_DEPTH];
    logic [1:0]  r_wptr;
    logic [1:0]  r_rptr;
    logic [2:0]  r_count;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_count == 3'd0);
    assign o_full  = (r_count == 3'(SKID_DEPTH));
    assign o_count = r_count;
    assign o_data  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else if (i_flush) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 2'd1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 2'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ahci_fis_transmit.sv
// rtl/ahci_fis_transmit.sv - host-to-device FIS transmitter (command FIS and data FIS)
//
// Ports:
//   mclk, hba_rst            clock, asynchronous active-high reset
//   send_cfis, cfis_len,
//   ct_addr                  start command FIS of cfis_len DWORDs read from ct_addr
//   send_dmah, dx_lenm1,
//   pm_port                  start data FIS: header then dx_lenm1+1 DMA DWORDs
//   abort                    abandon the FIS in progress (reports done_err)
//   reg_re, reg_raddr,
//   reg_rdata                register memory read port, data 2 cycles after reg_re
//   dma_valid, dma_data,
//   dma_re                   DMA engine DWORD source
//   todev_data/type/valid,
//   todev_ready              stream to transport FIFO (type 0 data, 1 head, 2 last)
//   xmit_ok, xmit_err        transport status for the FIS just sent
//   busy, done_ok, done_err  progress and sticky completion flags
module ahci_fis_transmit
    import ahci_fis_transmit_pkg::*;
#(
    parameter int ADDRESS_BITS = 10
) (
    input  logic                    mclk,
    input  logic                    hba_rst,
    input  logic                    send_cfis,
    input  logic                    send_dmah,
    input  logic [4:0]              cfis_len,
    input  logic [ADDRESS_BITS-1:0] ct_addr,
    input  logic [10:0]             dx_lenm1,
    input  logic [3:0]              pm_port,
    input  logic                    abort,
    output logic                    reg_re,
    output logic [ADDRESS_BITS-1:0] reg_raddr,
    input  logic [31:0]             reg_rdata,
    input  logic                    dma_valid,
    input  logic [31:0]             dma_data,
    output logic                    dma_re,
    output logic [31:0]             todev_data,
    output logic [1:0]              todev_type,
    output logic                    todev_valid,
    input  logic                    todev_ready,
    input  logic                    xmit_ok,
    input  logic                    xmit_err,
    output logic                    busy,
    output logic                    done_ok,
    output logic                    done_err
);

    xmit_state_t             r_state;
    xmit_state_t             w_state_next;
    logic [4:0]              r_len;
    logic [4:0]              r_rd_cnt;
    logic [4:0]              r_push_cnt;
    logic [ADDRESS_BITS-1:0] r_base;
    logic [10:0]             r_dcnt;
    logic [3:0]              r_pm;
    logic [1:0]              r_pipe;      // reg_re delayed by 1 and 2 cycles
    logic                    r_done_ok;
    logic                    r_done_err;

    logic                    w_accept;
    logic                    w_abort;
    logic                    w_push;
    logic [1:0]              w_push_type;
    logic [2:0]              w_inflight;
    logic                    w_skid_pop;
    logic [33:0]             w_skid_head;
    logic [2:0]              w_skid_count;
    logic                    w_skid_empty;
    logic                    w_skid_full;

    assign w_accept   = (r_state == ST_IDLE) && (send_cfis || send_dmah);
    assign w_abort    = abort && (r_state != ST_IDLE);
    assign w_push     = r_pipe[1] && (r_state == ST_CFIS);
    assign w_inflight = {2'b00, r_pipe[0]} + {2'b00, r_pipe[1]};

    // Type is fixed when the DWORD enters the buffer, so the output side
    // needs no knowledge of the FIS length.
    assign w_push_type = (r_push_cnt == 5'd0)          ? TODEV_HEAD :
                         (r_push_cnt == r_len - 5'd1)  ? TODEV_LAST : TODEV_DATA;

    assign busy     = (r_state != ST_IDLE);
    assign done_ok  = r_done_ok;
    assign done_err = r_done_err;

    ahci_fis_xmit_skid u_skid (
        .i_clk   (mclk),
        .i_rst   (hba_rst),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_data  ({w_push_type, reg_rdata}),
        .i_pop   (w_skid_pop),
        .o_data  (w_skid_head),
        .o_count (w_skid_count),
        .o_empty (w_skid_empty),
        .o_full  (w_skid_full)
    );

    always_comb begin
        w_state_next = r_state;
        reg_re       = 1'b0;
        reg_raddr    = '0;
        dma_re       = 1'b0;
        todev_valid  = 1'b0;
        todev_data   = 32'h0;
        todev_type   = TODEV_DATA;
        w_skid_pop   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_cfis) begin
                    w_state_next = ST_CFIS;
                end else if (send_dmah) begin
                    w_state_next = ST_DHEAD;
                end
            end
            ST_CFIS: begin
                // Reads still in flight will land in the buffer, so they
                // count against its capacity before a new read is issued.
                reg_re      = (r_rd_cnt < r_len) && !w_skid_full &&
                              ((w_skid_count + w_inflight) < 3'(SKID_DEPTH));
                reg_raddr   = reg_re ? (r_base + ADDRESS_BITS'(r_rd_cnt)) : '0;
                todev_valid = !w_skid_empty;
                todev_data  = w_skid_head[31:0];
                todev_type  = w_skid_head[33:32];
                w_skid_pop  = todev_valid && todev_ready;
                if (w_skid_pop && (w_skid_head[33:32] == TODEV_LAST)) begin
                    w_state_next = ST_WSTAT;
                end
            end
            ST_DHEAD: begin
                todev_valid = 1'b1;
                todev_data  = data_fis_header(r_pm);
                todev_type  = TODEV_HEAD;
                if (todev_ready) begin
                    w_state_next = ST_DDATA;
                end
            end
            ST_DDATA: begin
                todev_valid = dma_valid;
                todev_data  = dma_data;
                todev_type  = (r_dcnt == 11'd0) ? TODEV_LAST : TODEV_DATA;
                dma_re      = dma_valid && todev_ready;
                if (dma_re && (r_dcnt == 11'd0)) begin
                    w_state_next = ST_WSTAT;
                end
            end
            ST_WSTAT: begin
                if (xmit_ok || xmit_err) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge mclk or posedge hba_rst) begin
        if (hba_rst) begin
            r_state    <= ST_IDLE;
            r_len      <= 5'd0;
            r_rd_cnt   <= 5'd0;
            r_push_cnt <= 5'd0;
            r_base     <= '0;
            r_dcnt     <= 11'd0;
            r_pm       <= 4'd0;
            r_pipe     <= 2'b00;
            r_done_ok  <= 1'b0;
            r_done_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            // Clearing the delay line on abort discards reads already issued.
            r_pipe  <= w_abort ? 2'b00 : {r_pipe[0], reg_re};
            if (w_accept) begin
                r_done_ok  <= 1'b0;
                r_done_err <= 1'b0;
                r_len      <= (cfis_len < 5'd2) ? 5'd2 : cfis_len;
                r_base     <= ct_addr;
                r_rd_cnt   <= 5'd0;
                r_push_cnt <= 5'd0;
                r_dcnt     <= dx_lenm1;
                r_pm       <= pm_port;
            end else begin
                if (reg_re) begin
                    r_rd_cnt <= r_rd_cnt + 5'd1;
                end
                if (w_push) begin
                    r_push_cnt <= r_push_cnt + 5'd1;
                end
                if (dma_re) begin
                    r_dcnt <= r_dcnt - 11'd1;
                end
                if (w_abort) begin
                    r_done_err <= 1'b1;
                end else if (r_state == ST_WSTAT) begin
                    if (xmit_err) begin
                        r_done_err <= 1'b1;
                    end else if (xmit_ok) begin
                        r_done_ok <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ahci_fis_transmit.sv
// tb/tb_ahci_fis_transmit.sv - self-checking bench for ahci_fis_transmit
module tb_ahci_fis_transmit;

    logic        mclk;
    logic        hba_rst;
    logic        send_cfis;
    logic        send_dmah;
    logic [4:0]  cfis_len;
    logic [9:0]  ct_addr;
    logic [10:0] dx_lenm1;
    logic [3:0]  pm_port;
    logic        abort;
    logic        reg_re;
    logic [9:0]  reg_raddr;
    logic [31:0] reg_rdata;
    logic        dma_valid;
    logic [31:0] dma_data;
    logic        dma_re;
    logic [31:0] todev_data;
    logic [1:0]  todev_type;
    logic        todev_valid;
    logic        todev_ready;
    logic        xmit_ok;
    logic        xmit_err;
    logic        busy;
    logic        done_ok;
    logic        done_err;

    ahci_fis_transmit #(.ADDRESS_BITS(10)) dut (
        .mclk        (mclk),
        .hba_rst     (hba_rst),
        .send_cfis   (send_cfis),
        .send_dmah   (send_dmah),
        .cfis_len    (cfis_len),
        .ct_addr     (ct_addr),
        .dx_lenm1    (dx_lenm1),
        .pm_port     (pm_port),
        .abort       (abort),
        .reg_re      (reg_re),
        .reg_raddr   (reg_raddr),
        .reg_rdata   (reg_rdata),
        .dma_valid   (dma_valid),
        .dma_data    (dma_data),
        .dma_re      (dma_re),
        .todev_data  (todev_data),
        .todev_type  (todev_type),
        .todev_valid (todev_valid),
        .todev_ready (todev_ready),
        .xmit_ok     (xmit_ok),
        .xmit_err    (xmit_err),
        .busy        (busy),
        .done_ok     (done_ok),
        .done_err    (done_err)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hCF00_0000 + {22'd0, a};
    endfunction

    // Register memory: data for the address read in cycle t appears in cycle t+2.
    logic [9:0] m_cur, m_p1, m_p2;
    initial begin
        m_cur = '0;
        m_p1  = '0;
        m_p2  = '0;
    end
    always @(negedge mclk) m_cur = reg_raddr;
    always @(posedge mclk) begin
        m_p2 <= m_p1;
        m_p1 <= m_cur;
    end
    assign reg_rdata = mem_word(m_p2);

    // Monitor: records every accepted DWORD and protocol properties.
    logic [31:0] got_data[$];
    logic [1:0]  got_type[$];
    int          dma_re_cnt = 0;
    int          dma_bad = 0;
    int          outst = 0;
    int          max_outst = 0;
    int          stab_err = 0;
    logic        prev_stall = 1'b0;
    logic        prev_abort = 1'b0;
    logic [31:0] pd = '0;
    logic [1:0]  pt = '0;

    always @(negedge mclk) begin
        if (todev_valid && todev_ready) begin
            got_data.push_back(todev_data);
            got_type.push_back(todev_type);
        end
        if (dma_re) begin
            dma_re_cnt++;
            if (!dma_valid) dma_bad++;
        end
        outst = busy ? outst + (reg_re ? 1 : 0) - ((todev_valid && todev_ready) ? 1 : 0) : 0;
        if (outst > max_outst) max_outst = outst;
        if (prev_stall && !prev_abort &&
            !(todev_valid && todev_data === pd && todev_type === pt)) stab_err++;
        prev_stall = todev_valid && !todev_ready;
        prev_abort = abort;
        pd = todev_data;
        pt = todev_type;
    end

    // Stimulus driver for the DMA source and transport ready.
    logic ready_toggle = 1'b0;
    logic dma_gaps = 1'b0;
    logic limit_en = 1'b0;
    int   limit_abs = 0;
    int   dma_idx = 0;
    always @(posedge mclk) begin
        logic consumed;
        #1;
        consumed = 1'b0;
        if (dma_idx != dma_re_cnt) begin
            dma_idx  = dma_re_cnt;
            consumed = 1'b1;
        end
        if (!dma_valid || consumed)
            dma_valid = dma_gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        dma_data = 32'hD000_0000 + dma_idx;
        todev_ready = ready_toggle ? !todev_ready : 1'b1;
        if (limit_en && got_data.size() >= limit_abs) todev_ready = 1'b0;
    end

    typedef struct {
        bit          is_cfis;
        bit          both;
        logic [4:0]  len;
        logic [9:0]  addr;
        logic [10:0] dxm1;
        logic [3:0]  pm;
        bit          toggle;
        bit          gaps;
        bit          ok;
        bit          err;
        bit          exp_ok;
        bit          exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input string nm);
        int n, base, dre0, t;
        logic [31:0] ed;
        logic [1:0]  et;
        logic [9:0]  a;
        n = v.is_cfis ? ((v.len < 5'd2) ? 2 : int'(v.len)) : int'(v.dxm1) + 2;
        @(posedge mclk); #1;
        ready_toggle = v.toggle;
        dma_gaps     = v.gaps;
        base = got_data.size();
        dre0 = dma_re_cnt;
        send_cfis = v.is_cfis | v.both;
        send_dmah = !v.is_cfis | v.both;
        cfis_len  = v.len;
        ct_addr   = v.addr;
        dx_lenm1  = v.dxm1;
        pm_port   = v.pm;
        @(posedge mclk); #1;
        send_cfis = 1'b0;
        send_dmah = 1'b0;
        @(negedge mclk);
        chk({nm, "_busy_start"}, busy, 1);
        chk({nm, "_flags_cleared"}, {done_ok, done_err}, 0);
        t = 0;
        while (got_data.size() < base + n && t < 8000) begin
            @(posedge mclk);
            t++;
        end
        chk({nm, "_dword_count"}, got_data.size() - base, n);
        for (int i = 0; i < n; i++) begin
            if (v.is_cfis) begin
                a  = v.addr + 10'(i);
                ed = mem_word(a);
            end else if (i == 0) begin
                ed = {16'h0, 4'h0, v.pm, 8'h46};
            end else begin
                ed = 32'hD000_0000 + dre0 + i - 1;
            end
            et = (i == 0) ? 2'd1 : (i == n - 1) ? 2'd2 : 2'd0;
            if (base + i < got_data.size()) begin
                chk($sformatf("%s_data%0d", nm, i), got_data[base + i], ed);
                chk($sformatf("%s_type%0d", nm, i), got_type[base + i], et);
            end
        end
        repeat (4) @(negedge mclk);
        chk({nm, "_no_extra"}, got_data.size() - base, n);
        chk({nm, "_busy_wstat"}, busy, 1);
        if (!v.is_cfis) chk({nm, "_dma_re_count"}, dma_re_cnt - dre0, n - 1);
        @(posedge mclk); #1;
        xmit_ok  = v.ok;
        xmit_err = v.err;
        @(posedge mclk); #1;
        xmit_ok  = 1'b0;
        xmit_err = 1'b0;
        @(negedge mclk);
        chk({nm, "_done_ok"}, done_ok, v.exp_ok);
        chk({nm, "_done_err"}, done_err, v.exp_err);
        chk({nm, "_busy_end"}, busy, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int base, t, viol;
        //           cfis both len    addr     dxm1      pm   tog gap ok err eok eerr
        vecs[0] = '{1, 0, 5'd5,  10'h200, 11'd0,    4'd0, 0, 0, 1, 0, 1, 0};
        vecs[1] = '{1, 0, 5'd5,  10'h200, 11'd0,    4'd0, 1, 0, 1, 0, 1, 0};
        vecs[2] = '{0, 0, 5'd0,  10'h000, 11'd3,    4'd2, 0, 0, 0, 1, 0, 1};
        vecs[3] = '{0, 0, 5'd0,  10'h000, 11'd2047, 4'd5, 0, 1, 1, 0, 1, 0};
        vecs[4] = '{1, 1, 5'd1,  10'h3FF, 11'd9,    4'd7, 1, 0, 1, 1, 0, 1};
        vecs[5] = '{1, 0, 5'd16, 10'h3F8, 11'd0,    4'd0, 0, 0, 1, 0, 1, 0};

        hba_rst   = 1'b1;
        send_cfis = 1'b0;
        send_dmah = 1'b0;
        cfis_len  = '0;
        ct_addr   = '0;
        dx_lenm1  = '0;
        pm_port   = '0;
        abort     = 1'b0;
        xmit_ok   = 1'b0;
        xmit_err  = 1'b0;
        dma_valid = 1'b0;
        dma_data  = '0;
        todev_ready = 1'b1;
        repeat (2) @(negedge mclk);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done_ok, done_err}, 0);
        chk("rst_reg", {reg_re, 22'd0, reg_raddr}, 0);
        chk("rst_todev_valid", todev_valid, 0);
        chk("rst_todev_data", todev_data, 0);
        chk("rst_todev_type", todev_type, 0);
        chk("rst_dma_re", dma_re, 0);
        @(posedge mclk); #1;
        hba_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Abort a command FIS after two DWORDs have been accepted.
        @(posedge mclk); #1;
        ready_toggle = 1'b0;
        base = got_data.size();
        limit_abs = base + 2;
        limit_en  = 1'b1;
        send_cfis = 1'b1;
        cfis_len  = 5'd8;
        ct_addr   = 10'h100;
        @(posedge mclk); #1;
        send_cfis = 1'b0;
        t = 0;
        while (got_data.size() < base + 2 && t < 100) begin
            @(posedge mclk);
            t++;
        end
        repeat (3) @(posedge mclk);
        #1 abort = 1'b1;
        @(posedge mclk); #1;
        abort = 1'b0;
        limit_en = 1'b0;
        @(negedge mclk);
        chk("abort_busy", busy, 0);
        chk("abort_done_err", done_err, 1);
        chk("abort_done_ok", done_ok, 0);
        viol = 0;
        repeat (12) begin
            @(negedge mclk);
            if (todev_valid || reg_re) viol++;
        end
        chk("abort_quiet", viol, 0);
        chk("abort_count", got_data.size() - base, 2);
        if (got_data.size() >= base + 2) begin
            chk("abort_d0", got_data[base], mem_word(10'h100));
            chk("abort_d1", got_data[base + 1], mem_word(10'h101));
        end
        run_vec(vecs[0], "after_abort");

        // send_* while busy and status pulses outside WSTAT are ignored.
        @(posedge mclk); #1;
        base = got_data.size();
        send_cfis = 1'b1;
        cfis_len  = 5'd3;
        ct_addr   = 10'h050;
        @(posedge mclk); #1;
        send_cfis = 1'b0;
        t = 0;
        while (got_data.size() < base + 3 && t < 100) begin
            @(posedge mclk);
            t++;
        end
        repeat (3) @(posedge mclk);
        #1;
        send_cfis = 1'b1;
        send_dmah = 1'b1;
        cfis_len  = 5'd4;
        @(posedge mclk); #1;
        send_cfis = 1'b0;
        send_dmah = 1'b0;
        repeat (4) @(negedge mclk);
        chk("ign_busy", busy, 1);
        chk("ign_flags", {done_ok, done_err}, 0);
        chk("ign_count", got_data.size() - base, 3);
        if (got_data.size() >= base + 3) chk("ign_last_type", got_type[base + 2], 2);
        @(posedge mclk); #1;
        xmit_ok = 1'b1;
        @(posedge mclk); #1;
        xmit_ok = 1'b0;
        @(negedge mclk);
        chk("ign_done_ok", done_ok, 1);
        chk("ign_busy_end", busy, 0);
        @(posedge mclk); #1;
        xmit_err = 1'b1;
        @(posedge mclk); #1;
        xmit_err = 1'b0;
        repeat (2) @(negedge mclk);
        chk("idle_err_ignored", {done_ok, done_err}, 2'b10);
        chk("idle_busy", busy, 0);

        chk("max_buffered_le4", (max_outst <= 4) ? 1 : 0, 1);
        chk("hold_while_stalled", stab_err, 0);
        chk("dma_re_only_valid", dma_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
